// File: rtl/video_clk_pkg.sv
// video_clk_pkg: shared FSM type and default constants for the video clock-enable generator
package video_clk_pkg;
    typedef enum logic [1:0] {RESET, SETTLE, LOCKED} state_t;
    localparam int ACC_W_DEF = 32;
    localparam logic [31:0] INC_INIT_DEF = 32'd2158221066;
    localparam int CHAN_W = 3;
endpackage

// File: rtl/video_phase_acc.sv
// video_phase_acc: one fractional-rate phase accumulator producing a carry enable and MSB square wave
module video_phase_acc import video_clk_pkg::*; #(
    parameter int ACC_W = ACC_W_DEF,
    parameter logic [ACC_W-1:0] INC_INIT = ACC_W'(INC_INIT_DEF)
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             load,
    input  logic [ACC_W-1:0] load_inc,
    input  logic             clear,
    output logic             clk_en,
    output logic             outclk
);
    logic [ACC_W-1:0] acc, inc;
    logic [ACC_W:0]   sum;
    always_comb sum = {1'b0, acc} + {1'b0, inc};
    always_ff @(posedge refclk) begin
        if (!rst) begin
            acc    <= '0;
            inc    <= INC_INIT;
            clk_en <= 1'b0;
        end else if (load || clear) begin
            acc    <= '0;
            clk_en <= 1'b0;
            if (load) inc <= load_inc;
        end else begin
            {clk_en, acc} <= sum;
        end
    end
    assign outclk = acc[ACC_W-1];
endmodule

// File: rtl/video_clk_en_gen.sv
// video_clk_en_gen: multi-channel fractional clock-enable generator with run-time rate config and lock flag
module video_clk_en_gen import video_clk_pkg::*; #(
    parameter int NUM_CLOCKS = 2,
    parameter int ACC_W = ACC_W_DEF,
    parameter logic [ACC_W-1:0] INC_INIT = ACC_W'(INC_INIT_DEF),
    parameter int LOCK_CYCLES = 16
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CHAN_W-1:0]     cfg_chan,
    input  logic [ACC_W-1:0]      cfg_inc,
    input  logic                  sync_clear,
    output logic [NUM_CLOCKS-1:0] clk_en,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic                  cfg_err,
    output logic                  locked
);
    localparam int CNT_W = LOCK_CYCLES > 1 ? $clog2(LOCK_CYCLES) : 1;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             xfer, in_range, restart;
    always_comb begin
        xfer     = cfg_valid && cfg_ready;
        in_range = {29'd0, cfg_chan} < 32'(NUM_CLOCKS);
        restart  = xfer && in_range;
        state_n  = state;
        cnt_n    = cnt;
        if (state == RESET || restart) begin
            state_n = SETTLE;
            cnt_n   = '0;
        end else if (state == SETTLE) begin
            if (cnt == CNT_W'(LOCK_CYCLES - 1)) state_n = LOCKED;
            else cnt_n = cnt + 1'b1;
        end
    end
    always_ff @(posedge refclk) begin
        if (!rst) begin
            state   <= RESET;
            cnt     <= '0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            cfg_err <= xfer && !in_range;
        end
    end
    assign cfg_ready = state != RESET;
    assign locked    = state == LOCKED;
    for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_ch
        video_phase_acc #(.ACC_W(ACC_W), .INC_INIT(INC_INIT)) u_acc (
            .refclk   (refclk),
            .rst      (rst),
            .load     (restart && cfg_chan == CHAN_W'(i)),
            .load_inc (cfg_inc),
            .clear    (sync_clear),
            .clk_en   (clk_en[i]),
            .outclk   (outclk[i])
        );
    end
endmodule

// File: tb/tb_video_clk_en_gen.sv
// tb_video_clk_en_gen: scoreboard bench for the two-channel, 8-bit accumulator configuration
module tb_video_clk_en_gen;
    localparam int LOCK_CYCLES = 4;
    logic       refclk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [2:0] cfg_chan = 3'd0;
    logic [7:0] cfg_inc = 8'd0;
    logic       sync_clear = 1'b0;
    logic [1:0] clk_en, outclk;
    logic       cfg_err, locked;
    int         checks = 0;
    int         failures = 0;
    int         m_acc [2];
    int         m_inc [2];
    int         m_set;
    logic [6:0] exp_q [$];
    logic [6:0] obs, want;
    int         first, cnt;

    video_clk_en_gen #(.NUM_CLOCKS(2), .ACC_W(8), .INC_INIT(8'd64), .LOCK_CYCLES(LOCK_CYCLES)) dut (
        .refclk     (refclk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_chan   (cfg_chan),
        .cfg_inc    (cfg_inc),
        .sync_clear (sync_clear),
        .clk_en     (clk_en),
        .outclk     (outclk),
        .cfg_err    (cfg_err),
        .locked     (locked)
    );

    always #5 refclk = ~refclk;

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic model_reset();
        m_acc = '{0, 0};
        m_inc = '{64, 64};
        m_set = 0;
        exp_q.delete();
    endtask

    // Predict the outputs seen after the next edge and queue them as {clk_en, outclk, locked, cfg_err, cfg_ready}
    task automatic predict(input int ld_ch, input int ld_inc, input bit clr, input bit bad, input bit rel);
        logic [1:0] e, o;
        for (int i = 0; i < 2; i++) begin
            if (clr || ld_ch == i) begin
                if (ld_ch == i) m_inc[i] = ld_inc;
                m_acc[i] = 0;
                e[i] = 1'b0;
            end else begin
                e[i] = (m_acc[i] + m_inc[i]) >= 256;
                m_acc[i] = (m_acc[i] + m_inc[i]) % 256;
            end
            o[i] = m_acc[i] >= 128;
        end
        m_set = (rel || ld_ch >= 0) ? 0 : m_set + 1;
        exp_q.push_back({e, o, m_set >= LOCK_CYCLES, bad, 1'b1});
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        model_reset();
        obs = {clk_en, outclk, locked, cfg_err, cfg_ready};
        checks++;
        if (obs !== 7'd0) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", obs, 7'd0);
        end
    endtask

    task automatic test_lock();
        first = -1;
        rst = 1'b1;
        for (int k = 0; k < 16; k++) begin
            predict(-1, 0, 1'b0, 1'b0, k == 0);
            step();
            if (clk_en[0] && first < 0) first = k + 1;
            obs = {clk_en, outclk, locked, cfg_err, cfg_ready};
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL lock cyc=%0d got=%b exp=%b", k + 1, obs, want);
            end
        end
        checks++;
        if (first !== 4) begin
            failures++;
            $display("FAIL first_pulse got=%0d exp=4", first);
        end
    endtask

    task automatic test_cfg_chan1();
        first = -1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL cfg_ready got=%b exp=1", cfg_ready);
        end
        for (int k = 0; k < 24; k++) begin
            if (k == 0) begin
                cfg_valid = 1'b1;
                cfg_chan = 3'd1;
                cfg_inc = 8'd32;
                predict(1, 32, 1'b0, 1'b0, 1'b0);
            end else begin
                predict(-1, 0, 1'b0, 1'b0, 1'b0);
            end
            step();
            cfg_valid = 1'b0;
            if (clk_en[1] && first < 0) first = k;
            obs = {clk_en, outclk, locked, cfg_err, cfg_ready};
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL cfg_chan1 k=%0d got=%b exp=%b", k, obs, want);
            end
        end
        checks++;
        if (first !== 8) begin
            failures++;
            $display("FAIL chan1_first_pulse got=%0d exp=8", first);
        end
    endtask

    task automatic test_bad_chan();
        for (int k = 0; k < 8; k++) begin
            if (k == 0) begin
                cfg_valid = 1'b1;
                cfg_chan = 3'd5;
                cfg_inc = 8'd99;
            end
            predict(-1, 0, 1'b0, k == 0, 1'b0);
            step();
            cfg_valid = 1'b0;
            obs = {clk_en, outclk, locked, cfg_err, cfg_ready};
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL bad_chan k=%0d got=%b exp=%b", k, obs, want);
            end
        end
    endtask

    task automatic test_inc_zero();
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            if (k == 0) begin
                cfg_valid = 1'b1;
                cfg_chan = 3'd0;
                cfg_inc = 8'd0;
                predict(0, 0, 1'b0, 1'b0, 1'b0);
            end else begin
                predict(-1, 0, 1'b0, 1'b0, 1'b0);
            end
            step();
            cfg_valid = 1'b0;
            cnt += (clk_en[0] || outclk[0]) ? 1 : 0;
            obs = {clk_en, outclk, locked, cfg_err, cfg_ready};
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL inc_zero k=%0d got=%b exp=%b", k, obs, want);
            end
        end
        checks++;
        if (cnt !== 0) begin
            failures++;
            $display("FAIL inc_zero_frozen got=%0d exp=0", cnt);
        end
    endtask

    task automatic test_inc_192();
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (k == 0) begin
                cfg_valid = 1'b1;
                cfg_chan = 3'd0;
                cfg_inc = 8'd192;
                predict(0, 192, 1'b0, 1'b0, 1'b0);
            end else begin
                predict(-1, 0, 1'b0, 1'b0, 1'b0);
            end
            step();
            cfg_valid = 1'b0;
            if (k >= 1 && k <= 8) cnt += clk_en[0] ? 1 : 0;
            obs = {clk_en, outclk, locked, cfg_err, cfg_ready};
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL inc_192 k=%0d got=%b exp=%b", k, obs, want);
            end
        end
        checks++;
        if (cnt !== 6) begin
            failures++;
            $display("FAIL inc_192_carries got=%0d exp=6", cnt);
        end
    endtask

    task automatic test_sync_clear();
        for (int k = 0; k < 16; k++) begin
            sync_clear = k == 0;
            predict(-1, 0, k == 0, 1'b0, 1'b0);
            step();
            sync_clear = 1'b0;
            if (k == 0) begin
                checks++;
                if ({clk_en, outclk} !== 4'b0000) begin
                    failures++;
                    $display("FAIL clear_zero got=%b exp=0000", {clk_en, outclk});
                end
            end
            obs = {clk_en, outclk, locked, cfg_err, cfg_ready};
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL sync_clear k=%0d got=%b exp=%b", k, obs, want);
            end
        end
    endtask

    task automatic test_clear_with_cfg();
        for (int k = 0; k < 16; k++) begin
            if (k == 0) begin
                sync_clear = 1'b1;
                cfg_valid = 1'b1;
                cfg_chan = 3'd0;
                cfg_inc = 8'd64;
                predict(0, 64, 1'b1, 1'b0, 1'b0);
            end else begin
                predict(-1, 0, 1'b0, 1'b0, 1'b0);
            end
            step();
            sync_clear = 1'b0;
            cfg_valid = 1'b0;
            if (k == 8) begin
                checks++;
                if (clk_en !== 2'b11) begin
                    failures++;
                    $display("FAIL realign got=%b exp=11", clk_en);
                end
            end
            obs = {clk_en, outclk, locked, cfg_err, cfg_ready};
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL clear_cfg k=%0d got=%b exp=%b", k, obs, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2; k++) begin
            cfg_valid = k == 0;
            cfg_chan = 3'd1;
            cfg_inc = 8'd32;
            predict(k == 0 ? 1 : -1, 32, 1'b0, 1'b0, 1'b0);
            step();
            cfg_valid = 1'b0;
            obs = {clk_en, outclk, locked, cfg_err, cfg_ready};
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL pre_reset k=%0d got=%b exp=%b", k, obs, want);
            end
        end
        rst = 1'b0;
        cfg_valid = 1'b1;
        cfg_chan = 3'd1;
        cfg_inc = 8'd100;
        step();
        model_reset();
        obs = {clk_en, outclk, locked, cfg_err, cfg_ready};
        checks++;
        if (obs !== 7'd0) begin
            failures++;
            $display("FAIL mid_reset_state got=%b exp=%b", obs, 7'd0);
        end
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            predict(-1, 0, 1'b0, 1'b0, k == 0);
            step();
            cfg_valid = 1'b0;
            obs = {clk_en, outclk, locked, cfg_err, cfg_ready};
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL post_reset cyc=%0d got=%b exp=%b", k + 1, obs, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_cfg_chan1();
        test_bad_chan();
        test_inc_zero();
        test_inc_192();
        test_sync_clear();
        test_clear_with_cfg();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
